alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one combinational 8-bit ALU among NUM_REQ requesters.
- Each requester issues an operation {A, B, opcode} over a valid/ready handshake.
- The block round-robin arbitrates between requesters, drives the ALU operand and opcode ports from registers, and captures the result.
- The result is returned tagged with the requester ID over a valid/ready response channel.
- Sits between the client blocks and the shared ALU instance; the ALU lives outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (localparam), width of the requester ID.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  input  NUM_REQ*8  packed operand A; requester i uses bits [8i+7:8i].
- req_b  input  NUM_REQ*8  packed operand B; same packing as req_a.
- req_op  input  NUM_REQ*3  packed 3-bit ALU opcode; requester i uses bits [3i+2:3i].
- alu_a  output  8  operand A to the shared ALU.
- alu_b  output  8  operand B to the shared ALU.
- alu_opcode  output  3  opcode to the shared ALU.
- alu_result  input  8  combinational ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  8  result byte.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - alu_a, alu_b, alu_opcode = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to 0 combinationally while rst_n is low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant is combinational: the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready = one-hot of that grant; all zero if no request is valid.
  - Handshake: req_valid[g] & req_ready[g]. On the handshake, register alu_a/alu_b/alu_opcode from slice g, set rsp_id = g and rr_ptr = g, then go to EXEC.
- EXEC: operands are stable for one full cycle. At the end of the cycle, rsp_data <= alu_result, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid stays high, and rsp_id/rsp_data stay stable, until rsp_ready=1.
  - On the rsp handshake: rsp_valid <= 0, go to IDLE.
  - alu_* ports hold their last values (no toggling).
- req_ready is 0 in EXEC and RESP, so no request is accepted while an operation is outstanding.
- Latency: from request accept to rsp_valid is 2 cycles. Peak throughput is one op per 3 cycles with rsp_ready tied high.
- No back-to-back accept in the cycle of the rsp handshake; the next grant happens in IDLE on the following cycle.
- Arithmetic: the block does not modify data. Wrap, carry and shift semantics are entirely those of the ALU; rsp_data is exactly alu_result, 8 bits.
- Requesters must hold req_a/req_b/req_op stable while req_valid is high and not yet accepted. A requester deasserting req_valid before accept is legal; the grant is recomputed every IDLE cycle.
- Reset asserted mid-operation (EXEC or RESP): the operation is dropped with no response, all outputs take their reset values immediately, and the FSM is in IDLE after rst_n deasserts.
- rsp_ready high outside RESP is ignored.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed-priority grant where the lowest index wins; rr_ptr is removed and its search is not used.
- Undefined (default): round-robin grant as described in Behaviour.
- Ports, latency and the handshake are identical in both builds.

Decomposition:
- Package alu_pkg:
  - ALU_W = 8.
  - Opcode constants: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_NOT=3'b101, OP_SHL=3'b110, OP_SHR=3'b111.
  - FSM state typedef ctrl_state_t {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
  - Contains the ALU_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Single request: req 2, A=8'h0F, B=8'h01, OP_ADD, rsp_ready=1 -> req_ready[2] in cycle 0; rsp_valid in cycle 2 with rsp_id=2, rsp_data=8'h10; busy high for 2 cycles.
- Wrap: req 0, A=8'h00, B=8'h01, OP_SUB -> rsp_data=8'hFF, rsp_id=0.
- Fairness: all 4 req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0,1, each grant 3 cycles apart.
- Fixed priority: same stimulus with ALU_ARB_FIXED_PRIO_EN defined -> grant order 0,0,0,...
- Backpressure: OP_SHL, A=8'h81, rsp_ready low for 5 cycles -> rsp_valid held with rsp_data=8'h02 stable; req_ready stays 0 throughout; IDLE is reached one cycle after rsp_ready rises.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid=0, alu_*=0 and req_ready=0 immediately; no response is produced after release; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU sharing controller
//
// Purpose: data width, ALU opcode encodings and the controller FSM state type.
// Ports: none (package).
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational requester arbiter (round-robin or fixed priority)
//
// Purpose: picks one requester out of a request vector.
//   Default build: round-robin, searching upward from ptr+1 with wrap-around.
//   With ALU_ARB_FIXED_PRIO_EN defined: lowest index wins and ptr is not a port.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   ID_W     index of the last granted requester (round-robin build only)
//   gnt      out  NUM_REQ  one-hot grant, zero when no request
//   gnt_idx  out  ID_W     encoded grant index, zero when no request
//   gnt_any  out  1        at least one request is granted
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

`ifndef ALU_ARB_FIXED_PRIO_EN
    int                idx;
    logic [ID_W-1:0]   idx_w;
`endif

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Walk downward so the lowest requesting index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = ID_W'(i);
                gnt_any = 1'b1;
            end
        end
`else
        idx   = 0;
        idx_w = '0;
        // Walk the distance from ptr downward so the nearest requester after
        // ptr (distance 1 first) is the last one written.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (req[idx_w]) begin
                gnt_idx = idx_w;
                gnt_any = 1'b1;
            end
        end
`endif
        gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one external combinational ALU among NUM_REQ requesters
//
// Purpose: arbitrates requester operations, registers the chosen operands onto the
//   ALU ports for one full cycle, captures the result and returns it tagged with
//   the requester index. Build option ALU_ARB_FIXED_PRIO_EN selects fixed-priority
//   arbitration instead of round-robin.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b, req_op  packed per-requester operands and opcode
//   alu_a, alu_b, alu_opcode, alu_result   shared ALU interface
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      owning requester index and result byte
//   busy                  high whenever an operation is outstanding
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [ALU_W-1:0]        alu_a,
    output logic [ALU_W-1:0]        alu_b,
    output logic [OP_W-1:0]         alu_opcode,
    input  logic [ALU_W-1:0]        alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [ALU_W-1:0]        rsp_data,
    output logic                    busy
);

    ctrl_state_t        state;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [ALU_W-1:0]   sel_a;
    logic [ALU_W-1:0]   sel_b;
    logic [OP_W-1:0]    sel_op;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .ptr     (rr_ptr),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_a  = req_a[i*ALU_W +: ALU_W];
                sel_b  = req_b[i*ALU_W +: ALU_W];
                sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // The grant is only offered in IDLE; rst_n gates it so nothing can be
    // accepted while reset is held.
    assign req_ready = (rst_n && (state == IDLE)) ? gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr     <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    // gnt only selects a valid requester, so gnt_any is the handshake.
                    if (gnt_any) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_opcode <= sel_op;
                        rsp_id     <= gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr     <= gnt_idx;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [2:0]     alu_opcode;
    logic [7:0]     alu_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_ptr = N - 1;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_SHL:  return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_a, alu_b, alu_opcode);

    function automatic int model_grant(input logic [N-1:0] mask);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_op[i*3 +: 3] = op;
    endtask

    // Starts at posedge+1 in IDLE; ends at posedge+1 of the following IDLE cycle.
    task automatic run_op(input logic [N-1:0] mask, input int hold, input bit keep,
                          output int g, output logic [7:0] data);
        int           eg;
        logic [7:0]   ea, eb, ed;
        logic [2:0]   eo;
        logic [N-1:0] one = 1;
        req_valid = mask;
        rsp_ready = (hold == 0);
        eg = model_grant(mask);
        if (eg < 0) eg = 0;
        ea = req_a[eg*8 +: 8];
        eb = req_b[eg*8 +: 8];
        eo = req_op[eg*3 +: 3];
        ed = alu_f(ea, eb, eo);
        @(negedge clk);
        total_cnt++; if (req_ready !== (one << eg)) $display("FAIL grant: got %b expected %b", req_ready, one << eg); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL idle_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        @(posedge clk); #1;
        if (!keep) req_valid[eg] = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL exec_busy: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (req_ready !== '0) $display("FAIL exec_ready: got %b expected 0", req_ready); else pass_cnt++;
        total_cnt++; if ({alu_a, alu_b, alu_opcode} !== {ea, eb, eo}) $display("FAIL exec_operands: got %h/%h/%h expected %h/%h/%h", alu_a, alu_b, alu_opcode, ea, eb, eo); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL exec_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL resp_valid: got %b expected 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_id !== eg[1:0]) $display("FAIL resp_id: got %0d expected %0d", rsp_id, eg); else pass_cnt++;
        total_cnt++; if (rsp_data !== ed) $display("FAIL resp_data: got %h expected %h", rsp_data, ed); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || req_ready !== '0) $display("FAIL resp_busy_ready: got %b/%b expected 1/0", busy, req_ready); else pass_cnt++;
        g = rsp_id;
        data = rsp_data;
        for (int c = 1; c <= hold; c++) begin
            @(posedge clk); #1;
            if (c == hold) rsp_ready = 1'b1;
            @(negedge clk);
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_id !== eg[1:0]) $display("FAIL hold_stable: got %b/%h/%0d expected 1/%h/%0d", rsp_valid, rsp_data, rsp_id, ed, eg); else pass_cnt++;
            total_cnt++; if (req_ready !== '0 || {alu_a, alu_b, alu_opcode} !== {ea, eb, eo}) $display("FAIL hold_ready_alu: got %b/%h expected 0/%h", req_ready, {alu_a, alu_b, alu_opcode}, {ea, eb, eo}); else pass_cnt++;
        end
        @(posedge clk); #1;
        model_ptr = eg;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        #1;
        req_valid = '1;
        #1;
        total_cnt++; if (req_ready !== '0) $display("FAIL reset_ready: got %b expected 0", req_ready); else pass_cnt++;
        total_cnt++; if ({rsp_valid, rsp_id, rsp_data} !== 11'd0) $display("FAIL reset_rsp: got %b/%0d/%h expected 0/0/00", rsp_valid, rsp_id, rsp_data); else pass_cnt++;
        total_cnt++; if ({alu_a, alu_b, alu_opcode} !== 19'd0) $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_opcode}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        req_valid = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_ptr = N - 1;
    endtask

    task automatic test_fairness;
        int         g;
        logic [7:0] d;
        int         exp_g;
        for (int i = 0; i < N; i++) set_slot(i, 8'($urandom), 8'($urandom), 3'($urandom));
        for (int n = 0; n < 6; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = n % N;
`endif
            run_op('1, 0, 1'b1, g, d);
            total_cnt++; if (g !== exp_g) $display("FAIL fairness_order[%0d]: got %0d expected %0d", n, g, exp_g); else pass_cnt++;
        end
        req_valid = '0;
    endtask

    task automatic test_single;
        int         g;
        logic [7:0] d;
        set_slot(2, 8'h0F, 8'h01, OP_ADD);
        run_op(4'b0100, 0, 1'b0, g, d);
        total_cnt++; if (g !== 2 || d !== 8'h10) $display("FAIL single: got id %0d data %h expected id 2 data 10", g, d); else pass_cnt++;
    endtask

    task automatic test_wrap;
        int         g;
        logic [7:0] d;
        set_slot(0, 8'h00, 8'h01, OP_SUB);
        run_op(4'b0001, 0, 1'b0, g, d);
        total_cnt++; if (g !== 0 || d !== 8'hFF) $display("FAIL wrap: got id %0d data %h expected id 0 data FF", g, d); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int         g;
        logic [7:0] d;
        set_slot(3, 8'h81, 8'($urandom), OP_SHL);
        run_op(4'b1000, 5, 1'b0, g, d);
        total_cnt++; if (g !== 3 || d !== 8'h02) $display("FAIL backpressure: got id %0d data %h expected id 3 data 02", g, d); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_idle: got busy %b valid %b expected 0/0", busy, rsp_valid); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int           g;
        logic [7:0]   d;
        logic [N-1:0] mask;
        for (int n = 0; n < 24; n++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) if (mask[i]) set_slot(i, 8'($urandom), 8'($urandom), 3'($urandom));
            run_op(mask, $urandom_range(0, 3), 1'b0, g, d);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_op;
        int         g;
        logic [7:0] d;
        set_slot(1, 8'hA5, 8'h3C, OP_XOR);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if ({alu_a, alu_b, alu_opcode} !== 19'd0) $display("FAIL midrst_alu: got %h expected 0", {alu_a, alu_b, alu_opcode}); else pass_cnt++;
        total_cnt++; if (req_ready !== '0 || busy !== 1'b0) $display("FAIL midrst_ready_busy: got %b/%b expected 0/0", req_ready, busy); else pass_cnt++;
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        model_ptr = N - 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_no_rsp[%0d]: got %b/%b expected 0/0", c, rsp_valid, busy); else pass_cnt++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) set_slot(i, 8'($urandom), 8'($urandom), 3'($urandom));
        run_op('1, 0, 1'b0, g, d);
        total_cnt++; if (g !== 0) $display("FAIL midrst_first_grant: got %0d expected 0", g); else pass_cnt++;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
